// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: segment patterns, scan FSM states and the
// BCD-to-segment decode function used by the scan controller.
package seg7_pkg;

  // Segment patterns {a,b,c,d,e,f,g}, bit 6 = a, 1 = lit.
  localparam logic [6:0] SEG_0   = 7'b1111110;
  localparam logic [6:0] SEG_1   = 7'b0110000;
  localparam logic [6:0] SEG_2   = 7'b1101101;
  localparam logic [6:0] SEG_3   = 7'b1111001;
  localparam logic [6:0] SEG_4   = 7'b0110011;
  localparam logic [6:0] SEG_5   = 7'b1011011;
  localparam logic [6:0] SEG_6   = 7'b1011111;
  localparam logic [6:0] SEG_7   = 7'b1110000;
  localparam logic [6:0] SEG_8   = 7'b1111111;
  localparam logic [6:0] SEG_9   = 7'b1111011;
  localparam logic [6:0] SEG_OFF = 7'b0000000;

  // Per-slot scan phase: all digits dark, then the selected digit lit.
  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_t;

  // Non-BCD codes 10..15 decode to a dark digit.
  function automatic logic [6:0] seg7_decode(input logic [3:0] bcd);
    case (bcd)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_OFF;
    endcase
  endfunction

endpackage

// File: rtl/bcd_seg7_decode.sv
// Combinational BCD-to-7-segment decoder; one instance is shared by all
// digits behind the scan multiplexer.
module bcd_seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Pure table lookup; invalid codes map to SEG_OFF inside the function.
  always_comb begin
    seg = seg7g_default();
    seg = seg7_decode(bcd);
  end

  function automatic logic [6:0] seg7g_default();
    return SEG_OFF;
  endfunction

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller: double-buffered BCD word, round-robin
// digit scan with a blanking gap at each slot start, optional leading-zero
// suppression, and fully registered segment/digit outputs.
module seven_seg_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    blank_lz,
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_done
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] LAST_BLANK = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] LAST_SLOT  = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_DIGITS - 1);

  if (NUM_DIGITS < 2 || NUM_DIGITS > 8 || BLANK_CYCLES < 1 ||
      BLANK_CYCLES >= REFRESH_DIV) begin : g_param_check
    $error("seven_seg_scan_ctrl: illegal NUM_DIGITS/REFRESH_DIV/BLANK_CYCLES");
  end

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q;
  logic [IW-1:0]           idx_q;
  logic [4*NUM_DIGITS-1:0] shadow_bcd, act_bcd;
  logic [NUM_DIGITS-1:0]   shadow_dp, act_dp;
  logic                    shadow_lz, act_lz;
  logic [3:0]              act_digit [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   lz_blank;
  logic                    upper_zero;
  logic [6:0]              dec_seg;
  logic                    slot_end, wrap;

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digits
    assign act_digit[k] = act_bcd[4*k +: 4];
  end

  // The counter only reaches LAST_SLOT in SHOW, since BLANK ends earlier.
  assign slot_end = (cnt_q == LAST_SLOT);
  assign wrap     = slot_end && (idx_q == LAST_IDX);

  // Next-state logic for the two-phase slot FSM.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      BLANK:   if (cnt_q == LAST_BLANK) state_d = SHOW;
      SHOW:    if (slot_end)            state_d = BLANK;
      default: state_d = BLANK;
    endcase
  end

  // Slot counter, FSM state and active digit index.
  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BLANK;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= slot_end ? '0 : cnt_q + CW'(1);
      if (slot_end) idx_q <= (idx_q == LAST_IDX) ? '0 : idx_q + IW'(1);
    end
  end

  // Double buffer: loads land in the shadow; the active copy only changes at
  // the frame boundary, with a coincident load bypassing straight to active.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_bcd <= '0;
      shadow_dp  <= '0;
      shadow_lz  <= 1'b0;
      act_bcd    <= '0;
      act_dp     <= '0;
      act_lz     <= 1'b0;
    end else begin
      if (load) begin
        shadow_bcd <= bcd_in;
        shadow_dp  <= dp_in;
        shadow_lz  <= blank_lz;
      end
      if (wrap) begin
        act_bcd <= load ? bcd_in   : shadow_bcd;
        act_dp  <= load ? dp_in    : shadow_dp;
        act_lz  <= load ? blank_lz : shadow_lz;
      end
    end
  end

  // Leading-zero mask: digit k is dark when it and every more significant
  // digit are zero; digit 0 always stays lit.
  always_comb begin
    lz_blank   = '0;
    upper_zero = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      upper_zero  = upper_zero && (act_digit[k] == 4'd0);
      lz_blank[k] = act_lz && upper_zero && (k != 0);
    end
  end

  bcd_seg7_decode u_dec (
    .bcd (act_digit[idx_q]),
    .seg (dec_seg)
  );

  // Registered outputs: digit select, segments and dp all switch on one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_out    <= SEG_OFF;
      dp_out     <= 1'b0;
      digit_en   <= '0;
      frame_done <= 1'b0;
    end else if (state_q == SHOW) begin
      seg_out    <= lz_blank[idx_q] ? SEG_OFF : dec_seg;
      dp_out     <= act_dp[idx_q];
      digit_en   <= NUM_DIGITS'(1) << idx_q;
      frame_done <= wrap;
    end else begin
      seg_out    <= SEG_OFF;
      dp_out     <= 1'b0;
      digit_en   <= '0;
      frame_done <= 1'b0;
    end
  end

endmodule
